permutation_inv: RTL and testbench
==================================

PERMUTATION_INV -- requirements
Module: permutation_inv

Interface
REQ-001 Parameter NUM_ROUNDS, default 1, sets the number of inverse rounds applied (1..24).
REQ-002 Parameter LANE_W, default 64, sets the lane width in bits; all rotations are taken mod LANE_W.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  begin a decode when sampled high in IDLE.
REQ-006 in_valid  input  1  in_lane holds a valid encoded lane.
REQ-007 in_lane  input  LANE_W  encoded lane, lane index order i = x+5y, i = 0..24.
REQ-008 in_ready  output  1  block accepts a lane this cycle.
REQ-009 out_valid  output  1  out_lane holds a valid decoded lane.
REQ-010 out_lane  output  LANE_W  decoded lane, emitted in order i = 0..24.
REQ-011 out_ready  input  1  sink accepts out_lane this cycle.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after lane 24 is accepted by the sink.

Function
REQ-014 The block shall undo NUM_ROUNDS encoder rounds; each encoder round is rho then pi, so each inverse round is inverse-pi then inverse-rho.
REQ-015 Inverse-pi: A[(X+3Y) mod 5][X] = B[X][Y] for all X,Y in 0..4.
REQ-016 Inverse-rho: A[x][y] = rotate-right(A[x][y], r[x][y]); r for i = 0..24 is 0,1,62,28,27,36,44,6,55,20,3,10,43,25,39,41,45,15,21,8,18,2,61,56,14.
REQ-017 The FSM shall have the states IDLE, LOAD, ROUND, DRAIN and DONE.
REQ-018 IDLE: start=1 -> LOAD; lane counter cleared; round counter cleared.
REQ-019 LOAD: in_ready=1; each cycle with in_valid=1 stores in_lane at index counter and increments the counter; after lane 24 -> ROUND.
REQ-020 ROUND: one full inverse round per clock over all 25 lanes in parallel; after NUM_ROUNDS cycles -> DRAIN.
REQ-021 DRAIN: out_valid=1, out_lane = lane[counter]; the counter advances only when out_valid and out_ready are both high; after the lane-24 handshake -> DONE.
REQ-022 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-023 out_lane and out_valid shall be held stable while out_ready=0 (no lane dropped or duplicated).
REQ-024 in_ready shall be 0 outside LOAD; in_valid outside LOAD is ignored.
REQ-025 start shall be ignored outside IDLE.
REQ-026 start held high through DONE shall start a new decode on the cycle after return to IDLE.
REQ-027 Latency from start accepted to first out_valid = 25 load cycles (no stalls) + NUM_ROUNDS.
REQ-028 Gaps on in_valid shall stall LOAD without loss.
REQ-029 The lane counter is 5 bits; the round counter is sized for 24.

Reset
REQ-030 rst low shall asynchronously force IDLE, clear both counters, and drive in_ready=0, out_valid=0, out_lane=0, busy=0, done=0.
REQ-031 The lane buffer need not be cleared by reset.
REQ-032 Reset asserted in any state, including mid-LOAD and mid-DRAIN, shall abort the operation; a following start shall begin a fresh decode with no residue observable on the outputs.

Verification
REQ-033 NUM_ROUNDS=1, in_lane[0]=0x0123456789ABCDEF and all other lanes 0 -> out lane 0 = 0x0123456789ABCDEF, all other lanes 0.
REQ-034 NUM_ROUNDS=1, in_lane[1]=0x2 and all other lanes 0 -> out lane 6 = 0x0000000000200000, all other lanes 0, done one cycle after lane 24.
REQ-035 Round trip: reference encoder model (rho then pi, NUM_ROUNDS=3) applied to 10 random states, then decoded -> output equals the original state bit-exactly.
REQ-036 Backpressure: out_ready toggled pseudo-randomly and in_valid with random gaps -> 25 lanes out in order with no duplicates, and out_lane stable while stalled.
REQ-037 rst pulsed low after 12 lanes loaded -> busy=0 and in_ready=0 immediately; a new start plus 25 lanes decodes correctly.
REQ-038 start pulsed during ROUND and DRAIN -> no effect; exactly one done pulse per decode.

Source files
------------

// File: rtl/permutation_inv_if.sv
// Lane stream bundle for the inverse rho/pi permutation block.
// Carries start, the input and output lane handshakes, and status.
interface permutation_inv_if #(
  parameter int LANE_W = 64
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [LANE_W-1:0] in_lane;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_lane;
  logic              busy;
  logic              done;

  modport master (
    output start, in_valid, in_lane, out_ready,
    input  in_ready, out_valid, out_lane, busy, done
  );

  modport slave (
    input  start, in_valid, in_lane, out_ready,
    output in_ready, out_valid, out_lane, busy, done
  );
endinterface

// File: rtl/permutation_inv.sv
// Inverse permutation: loads 25 lanes, applies NUM_ROUNDS inverse
// rounds (inverse-pi then inverse-rho), then streams the lanes out.
module permutation_inv #(
  parameter int NUM_ROUNDS = 1,
  parameter int LANE_W     = 64
) (
  input logic              clk,
  input logic              rst,
  permutation_inv_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned RHO [25] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  localparam logic [4:0] LAST_LANE = 5'd24;
  localparam logic [4:0] LAST_RND  = 5'(NUM_ROUNDS - 1);

  state_t            state;
  logic [4:0]        cnt;
  logic [4:0]        rnd;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [LANE_W-1:0] out_lane_q;
  logic              busy_q;
  logic              done_q;

  logic [LANE_W-1:0] lanes [25];
  logic [LANE_W-1:0] nxt   [25];

  function automatic logic [LANE_W-1:0] rotr(
    input logic [LANE_W-1:0] v,
    input int unsigned       s
  );
    return LANE_W'({v, v} >> s);
  endfunction

  // Lane (X,Y) lands at ((X+3Y)%5, X) and is then rotated right
  // by the offset belonging to its destination.
  always_comb begin
    nxt = lanes;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        nxt[(x + 3 * y) % 5 + 5 * x] =
          rotr(lanes[x + 5 * y],
               RHO[(x + 3 * y) % 5 + 5 * x] % LANE_W);
      end
    end
  end

  // Lane buffer carries no reset; the FSM never reads stale lanes.
  always_ff @(posedge clk) begin
    if (state == LOAD && bus.in_valid) begin
      lanes[cnt] <= bus.in_lane;
    end else if (state == ROUND) begin
      lanes <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rnd         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_lane_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= LOAD;
            cnt        <= '0;
            rnd        <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            if (cnt == LAST_LANE) begin
              state      <= ROUND;
              cnt        <= '0;
              in_ready_q <= 1'b0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        ROUND: begin
          if (rnd == LAST_RND) begin
            state       <= DRAIN;
            out_valid_q <= 1'b1;
            out_lane_q  <= nxt[0];
          end else begin
            rnd <= rnd + 5'd1;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (cnt == LAST_LANE) begin
              state       <= DONE;
              cnt         <= '0;
              out_valid_q <= 1'b0;
              out_lane_q  <= '0;
              done_q      <= 1'b1;
            end else begin
              cnt        <= cnt + 5'd1;
              out_lane_q <= lanes[cnt + 5'd1];
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_lane  = out_lane_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_permutation_inv.sv
// Directed bench for permutation_inv: one instance with 1 round,
// one with 3 rounds, sharing the stimulus and selected by sel.
module tb_permutation_inv;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] in_lane;
  logic        sel;

  int total;
  int bad;

  logic [63:0] ld  [25];
  logic [63:0] ex  [25];
  logic [63:0] got [25];

  localparam int unsigned RHO [25] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  permutation_inv_if #(.LANE_W(64)) b1 ();
  permutation_inv_if #(.LANE_W(64)) b3 ();

  assign b1.start     = start & ~sel;
  assign b3.start     = start & sel;
  assign b1.in_valid  = in_valid;
  assign b3.in_valid  = in_valid;
  assign b1.in_lane   = in_lane;
  assign b3.in_lane   = in_lane;
  assign b1.out_ready = out_ready;
  assign b3.out_ready = out_ready;

  permutation_inv #(.NUM_ROUNDS(1), .LANE_W(64)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  permutation_inv #(.NUM_ROUNDS(3), .LANE_W(64)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  wire        o_in_ready  = sel ? b3.in_ready  : b1.in_ready;
  wire        o_out_valid = sel ? b3.out_valid : b1.out_valid;
  wire [63:0] o_out_lane  = sel ? b3.out_lane  : b1.out_lane;
  wire        o_busy      = sel ? b3.busy      : b1.busy;
  wire        o_done      = sel ? b3.done      : b1.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] v,
                                       input int unsigned s);
    return (s == 0) ? v : ((v << s) | (v >> (64 - s)));
  endfunction

  // Reference encoder: rho then pi, nr rounds, from ex into ld.
  function automatic void encode(input int nr);
    logic [63:0] a [25];
    logic [63:0] b [25];
    a = ex;
    for (int r = 0; r < nr; r++) begin
      for (int i = 0; i < 25; i++) a[i] = rotl(a[i], RHO[i]);
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          b[x + 5 * y] = a[(x + 3 * y) % 5 + 5 * x];
      a = b;
    end
    ld = a;
  endfunction

  task automatic clear_vecs();
    for (int i = 0; i < 25; i++) begin
      ld[i] = '0;
      ex[i] = '0;
    end
  endtask

  task automatic rand_state();
    for (int i = 0; i < 25; i++) ex[i] = {$urandom, $urandom};
  endtask

  task automatic begin_dec();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", o_busy, 1);
    chk("start_ready", o_in_ready, 1);
  endtask

  task automatic feed(input bit gaps);
    int i;
    int cyc;
    i   = 0;
    cyc = 0;
    while (i < 25 && cyc < 500) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_lane  = ld[i];
      if (in_valid && o_in_ready) i++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("load_count", i, 25);
    chk("ready_off", o_in_ready, 0);
  endtask

  task automatic drain(input int nr, input bit bp,
                       input bit poke, input bit hold);
    int          w;
    int          j;
    int          cyc;
    int          dn;
    logic        stalled;
    logic [63:0] held;
    w  = 0;
    dn = 0;
    while (!o_out_valid && w < 40) begin
      if (poke) start = 1'b1;
      tick();
      w++;
      if (o_done) dn++;
    end
    start = hold;
    chk("latency", w, nr);
    j   = 0;
    cyc = 0;
    while (j < 25 && cyc < 2000) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) start = (j < 20) ? 1'(cyc % 2) : 1'b0;
      if (hold) start = 1'b1;
      if (o_out_valid && out_ready) begin
        got[j] = o_out_lane;
        j++;
      end
      stalled = o_out_valid && !out_ready;
      held    = o_out_lane;
      tick();
      cyc++;
      if (o_done) dn++;
      if (stalled) begin
        chk("stall_valid", o_out_valid, 1);
        chk("stall_lane", o_out_lane, held);
      end
    end
    out_ready = 1'b0;
    chk("drain_count", j, 25);
    chk("done_pulse", o_done, 1);
    if (!hold) start = 1'b0;
    tick();
    if (o_done) dn++;
    chk("done_clear", o_done, 0);
    chk("idle_busy", o_busy, 0);
    chk("done_count", dn, 1);
  endtask

  task automatic compare(input string tag);
    for (int k = 0; k < 25; k++)
      chk($sformatf("%s_lane%0d", tag, k), got[k], ex[k]);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_lane   = '0;
    out_ready = 1'b0;
    sel       = 1'b0;

    #12;
    chk("rst_in_ready", b1.in_ready, 0);
    chk("rst_out_valid", b1.out_valid, 0);
    chk("rst_out_lane", b1.out_lane, 0);
    chk("rst_busy", b1.busy, 0);
    chk("rst_done", b1.done, 0);
    chk("rst_busy3", b3.busy, 0);
    rst = 1'b1;
    tick();

    // single lane 0 passes through untouched
    clear_vecs();
    ld[0] = 64'h0123456789ABCDEF;
    ex[0] = 64'h0123456789ABCDEF;
    begin_dec();
    feed(1'b0);
    drain(1, 1'b0, 1'b0, 1'b0);
    compare("v0");

    // lane 1 moves to lane 6, rotated right by 44
    clear_vecs();
    ld[1] = 64'h2;
    ex[6] = 64'h0000000000200000;
    begin_dec();
    feed(1'b0);
    drain(1, 1'b0, 1'b0, 1'b0);
    compare("v1");

    // round trip through 3 rounds
    sel = 1'b1;
    tick();
    for (int t = 0; t < 10; t++) begin
      rand_state();
      encode(3);
      begin_dec();
      feed(1'b0);
      drain(3, 1'b0, 1'b0, 1'b0);
      compare($sformatf("rt%0d", t));
    end

    // input gaps and output backpressure
    sel = 1'b0;
    tick();
    rand_state();
    encode(1);
    begin_dec();
    feed(1'b1);
    drain(1, 1'b1, 1'b0, 1'b0);
    compare("bp");

    // reset after 12 lanes loaded
    rand_state();
    encode(1);
    begin_dec();
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_lane  = ld[i];
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_load_busy", o_busy, 0);
    chk("mid_load_ready", o_in_ready, 0);
    #1;
    rst = 1'b1;
    tick();
    begin_dec();
    feed(1'b0);
    drain(1, 1'b0, 1'b0, 1'b0);
    compare("after_load_rst");

    // reset in the middle of draining
    rand_state();
    encode(1);
    begin_dec();
    feed(1'b0);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("mid_drain_valid", o_out_valid, 1);
    rst = 1'b0;
    #1;
    chk("drain_rst_valid", o_out_valid, 0);
    chk("drain_rst_lane", o_out_lane, 0);
    chk("drain_rst_busy", o_busy, 0);
    chk("drain_rst_done", o_done, 0);
    out_ready = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    clear_vecs();
    ld[1] = 64'h2;
    ex[6] = 64'h0000000000200000;
    begin_dec();
    feed(1'b0);
    drain(1, 1'b0, 1'b0, 1'b0);
    compare("after_drain_rst");

    // start pulses during ROUND and DRAIN are ignored
    sel = 1'b1;
    tick();
    rand_state();
    encode(3);
    begin_dec();
    feed(1'b0);
    drain(3, 1'b0, 1'b1, 1'b0);
    compare("poke");
    tick();
    chk("poke_stay_idle", o_busy, 0);

    // start held through DONE restarts right after IDLE
    sel = 1'b0;
    tick();
    rand_state();
    encode(1);
    begin_dec();
    feed(1'b0);
    drain(1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("restart_busy", o_busy, 1);
    chk("restart_ready", o_in_ready, 1);
    start = 1'b0;
    rand_state();
    encode(1);
    feed(1'b0);
    drain(1, 1'b0, 1'b0, 1'b0);
    compare("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
